// File: rtl/axis_dma_pkg.sv
// Shared types and helpers for the C2H frame path: frame width default,
// words-per-frame calculation and the output handshake state encoding.
package axis_dma_pkg;

   localparam int DATA_WIDTH_DEF = 4064;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      PRESENT   = 2'd1,
      WAIT_DONE = 2'd2
   } out_state_t;

   function automatic int words_per_frame(input int data_width, input int in_width);
      return data_width / in_width;
   endfunction

endpackage

// File: rtl/frame_pingpong_buf.sv
// Two frame buffers with a word-granular write port, a whole-buffer clear
// port and a combinational read mux.
module frame_pingpong_buf
   import axis_dma_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int IN_WIDTH   = 508,
   parameter int WORDS      = 8,
   parameter int IDX_W      = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wr_en,
   input  logic                  wr_sel,
   input  logic [IDX_W-1:0]      wr_idx,
   input  logic [IN_WIDTH-1:0]   wr_data,
   input  logic                  clr_en,
   input  logic                  clr_sel,
   input  logic                  rd_sel,
   output logic [DATA_WIDTH-1:0] rd_data
);

   logic [DATA_WIDTH-1:0] mem [2];

   // Clear and write never target the same buffer in one cycle: a buffer is
   // only cleared while full, and a full buffer is never written.
   always_ff @(posedge clk) begin
      if (rst) begin
         mem[0] <= '0;
         mem[1] <= '0;
      end else begin
         if (clr_en) mem[clr_sel] <= '0;
         for (int w = 0; w < WORDS; w++) begin
            if (wr_en && (wr_idx == IDX_W'(w)))
               mem[wr_sel][w*IN_WIDTH +: IN_WIDTH] <= wr_data;
         end
      end
   end

   assign rd_data = mem[rd_sel];

endmodule

// File: rtl/axis_frame_collector.sv
// Assembles IN_WIDTH words LSB-first into ping-pong buffered frames and hands
// them to the packer over its level data_next handshake. Optional macro:
// FRAME_DROP_ON_FULL_EN (drop whole frames instead of backpressuring).
module axis_frame_collector
   import axis_dma_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int IN_WIDTH   = 508,
   parameter int WORDS      = words_per_frame(DATA_WIDTH, IN_WIDTH)
) (
   input  logic                  m_axis_c2h_aclk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [IN_WIDTH-1:0]   in_data,
   input  logic                  in_last,
   output logic                  data_valid,
   output logic [DATA_WIDTH-1:0] data,
   input  logic                  data_next,
   output logic [1:0]            fifo_level,
   output logic                  frame_done
`ifdef FRAME_DROP_ON_FULL_EN
   ,
   output logic [15:0]           drop_cnt
`endif
);

   localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

   if (DATA_WIDTH % IN_WIDTH != 0) begin : g_width_check
      $error("axis_frame_collector: DATA_WIDTH must be a multiple of IN_WIDTH");
   end

   logic [1:0]       full;
   logic             wr_sel;
   logic             rd_sel;
   logic [IDX_W-1:0] word_idx;
   out_state_t       state;
   logic             accept;
   logic             last_word;
   logic             drop_now;
   logic             wr_en;
   logic             frame_end;
   logic             commit;
   logic             clr_en;
   logic [1:0]       set_mask;
   logic [1:0]       clr_mask;

`ifdef FRAME_DROP_ON_FULL_EN
   logic dropping;

   // The keep/drop decision is taken on word 0 and held for the whole frame,
   // so a buffer freed mid-frame never receives a partial frame.
   assign in_ready = 1'b1;
   assign drop_now = (word_idx == '0) ? full[wr_sel] : dropping;

   always_ff @(posedge m_axis_c2h_aclk) begin
      if (rst) begin
         dropping <= 1'b0;
         drop_cnt <= '0;
      end else begin
         if (accept) dropping <= drop_now;
         if (frame_end && drop_now && (drop_cnt != 16'hFFFF))
            drop_cnt <= drop_cnt + 16'd1;
      end
   end
`else
   assign in_ready = !full[wr_sel];
   assign drop_now = 1'b0;
`endif

   assign accept    = in_valid && in_ready;
   assign last_word = (word_idx == IDX_W'(WORDS - 1)) || in_last;
   assign wr_en     = accept && !drop_now;
   assign frame_end = accept && last_word;
   assign commit    = frame_end && !drop_now;
   assign clr_en    = (state == PRESENT) && !data_next;
   assign set_mask  = commit ? (wr_sel ? 2'b10 : 2'b01) : 2'b00;
   assign clr_mask  = clr_en ? (rd_sel ? 2'b10 : 2'b01) : 2'b00;

   always_ff @(posedge m_axis_c2h_aclk) begin
      if (rst) begin
         word_idx <= '0;
         wr_sel   <= 1'b0;
         full     <= 2'b00;
      end else begin
         if (frame_end)   word_idx <= '0;
         else if (accept) word_idx <= word_idx + 1'b1;
         if (commit) wr_sel <= !wr_sel;
         full <= (full | set_mask) & ~clr_mask;
      end
   end

   // WAIT_DONE holds off re-presentation until the packer reports idle again.
   always_ff @(posedge m_axis_c2h_aclk) begin
      if (rst) begin
         state      <= IDLE;
         data_valid <= 1'b0;
         frame_done <= 1'b0;
         rd_sel     <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         case (state)
            IDLE: begin
               if (full[rd_sel] && data_next) begin
                  state      <= PRESENT;
                  data_valid <= 1'b1;
               end
            end
            PRESENT: begin
               if (!data_next) begin
                  state      <= WAIT_DONE;
                  data_valid <= 1'b0;
                  rd_sel     <= !rd_sel;
                  frame_done <= 1'b1;
               end
            end
            WAIT_DONE: begin
               if (data_next) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign fifo_level = {1'b0, full[0]} + {1'b0, full[1]};

   frame_pingpong_buf #(
      .DATA_WIDTH (DATA_WIDTH),
      .IN_WIDTH   (IN_WIDTH),
      .WORDS      (WORDS),
      .IDX_W      (IDX_W)
   ) u_buf (
      .clk     (m_axis_c2h_aclk),
      .rst     (rst),
      .wr_en   (wr_en),
      .wr_sel  (wr_sel),
      .wr_idx  (word_idx),
      .wr_data (in_data),
      .clr_en  (clr_en),
      .clr_sel (rd_sel),
      .rd_sel  (rd_sel),
      .rd_data (data)
   );

endmodule
